// File: rtl/decode_sequencer.sv
// 6502 group-one decode sequencer: opcode accept, operand and pointer fetch,
// effective address, ALU launch and one-cycle register write enables.
module decode_sequencer #(
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int OPP_WIDTH   = 3,
  parameter int WE_WIDTH    = 3,
  parameter int ALU_TIMEOUT = 15,
  parameter int WE_ADD      = 0,
  parameter int WE_STAT     = 1,
  parameter int WE_DOUT     = 2,
  parameter logic [OPP_WIDTH-1:0] OPP_OR  = OPP_WIDTH'(0),
  parameter logic [OPP_WIDTH-1:0] OPP_AND = OPP_WIDTH'(1),
  parameter logic [OPP_WIDTH-1:0] OPP_XOR = OPP_WIDTH'(2),
  parameter logic [OPP_WIDTH-1:0] OPP_SUM = OPP_WIDTH'(3),
  parameter logic [OPP_WIDTH-1:0] OPP_SUB = OPP_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_WIDTH-1:0]  instr_in,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_inc,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic [REG_WIDTH-1:0]  operand,
  output logic [OPP_WIDTH-1:0]  opp,
  output logic                  alu_start,
  input  logic                  alu_done,
  output logic                  alu_update_status,
  output logic [WE_WIDTH-1:0]   we,
  output logic                  instr_done,
  output logic                  illegal,
  output logic                  fault
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI,
    S_READ, S_EXEC, S_ALU_WAIT, S_WB
  } state_t;

  state_t                state_q, state_d, after_addr;
  logic [2:0]            aaa_q, aaa_d;
  logic [2:0]            bbb_q, bbb_d;
  logic [REG_WIDTH-1:0]  lo_q, lo_d;
  logic [REG_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [REG_WIDTH-1:0]  operand_q, operand_d;
  logic [OPP_WIDTH-1:0]  opp_q, opp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WE_WIDTH-1:0]   we_q, we_d;
  logic pc_inc_q, pc_inc_d;
  logic start_q, start_d;
  logic done_q, done_d;
  logic ill_q, ill_d;
  logic fault_q, fault_d;

  logic                  is_sta, is_lda, is_cmp, is_alu;
  logic                  legal;
  logic [OPP_WIDTH-1:0]  dec_opp;
  logic [REG_WIDTH-1:0]  op_x;
  logic [REG_WIDTH-1:0]  idx;
  logic [ADDR_WIDTH-1:0] abs_ea;
  logic [ADDR_WIDTH-1:0] ptr_ea;

  assign is_sta = (aaa_q == 3'b100);
  assign is_lda = (aaa_q == 3'b101);
  assign is_cmp = (aaa_q == 3'b110);
  assign is_alu = !is_sta && !is_lda;

  assign legal = (instr_in[1:0] == 2'b01) &&
                 !(instr_in[7:5] == 3'b100 && instr_in[4:2] == 3'b010);

  always_comb begin
    dec_opp = OPP_OR;
    unique case (instr_in[7:5])
      3'b001:         dec_opp = OPP_AND;
      3'b010:         dec_opp = OPP_XOR;
      3'b011:         dec_opp = OPP_SUM;
      3'b110, 3'b111: dec_opp = OPP_SUB;
      default:        dec_opp = OPP_OR;
    endcase
  end

  // Zero-page sums stay REG_WIDTH wide so they wrap inside page zero.
  assign op_x   = mem_rdata + x_in;
  assign idx    = (bbb_q == 3'b110) ? y_in :
                  (bbb_q == 3'b111) ? x_in : '0;
  assign abs_ea = ADDR_WIDTH'({mem_rdata, lo_q}) + ADDR_WIDTH'(idx);
  assign ptr_ea = ADDR_WIDTH'({mem_rdata, lo_q}) +
                  ((bbb_q == 3'b100) ? ADDR_WIDTH'(y_in) : '0);
  assign after_addr = is_sta ? S_WB : S_READ;

  always_comb begin
    state_d   = state_q;
    aaa_d     = aaa_q;
    bbb_d     = bbb_q;
    lo_d      = lo_q;
    ptr_d     = ptr_q;
    ea_d      = ea_q;
    operand_d = operand_q;
    opp_d     = opp_q;
    cnt_d     = cnt_q;
    we_d      = '0;
    pc_inc_d  = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    ill_d     = 1'b0;
    fault_d   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = ea_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (legal) begin
            state_d = S_OP_LO;
            aaa_d   = instr_in[7:5];
            bbb_d   = instr_in[4:2];
            opp_d   = dec_opp;
          end else begin
            ill_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_OP_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc_in;
        if (mem_ack) begin
          pc_inc_d = 1'b1;
          unique case (bbb_q)
            3'b010: begin
              operand_d = mem_rdata;
              state_d   = is_lda ? S_WB : S_EXEC;
            end
            3'b001: begin
              ea_d    = ADDR_WIDTH'(mem_rdata);
              state_d = after_addr;
            end
            3'b101: begin
              ea_d    = ADDR_WIDTH'(op_x);
              state_d = after_addr;
            end
            3'b000: begin
              ptr_d   = op_x;
              state_d = S_PTR_LO;
            end
            3'b100: begin
              ptr_d   = mem_rdata;
              state_d = S_PTR_LO;
            end
            default: begin
              lo_d    = mem_rdata;
              state_d = S_OP_HI;
            end
          endcase
        end
      end
      S_OP_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc_in;
        if (mem_ack) begin
          pc_inc_d = 1'b1;
          ea_d     = abs_ea;
          state_d  = after_addr;
        end
      end
      S_PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(ptr_q);
        if (mem_ack) begin
          lo_d    = mem_rdata;
          ptr_d   = ptr_q + 1'b1;
          state_d = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(ptr_q);
        if (mem_ack) begin
          ea_d    = ptr_ea;
          state_d = after_addr;
        end
      end
      S_READ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          operand_d = mem_rdata;
          state_d   = is_lda ? S_WB : S_EXEC;
        end
      end
      S_EXEC: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_ALU_WAIT;
      end
      S_ALU_WAIT: begin
        if (alu_done) begin
          state_d = S_WB;
        end else if (cnt_q == CW'(ALU_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        unique case (1'b1)
          is_sta: we_d[WE_DOUT] = 1'b1;
          is_cmp: we_d[WE_STAT] = 1'b1;
          default: begin
            we_d[WE_ADD]  = 1'b1;
            we_d[WE_STAT] = 1'b1;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      aaa_q     <= '0;
      bbb_q     <= '0;
      lo_q      <= '0;
      ptr_q     <= '0;
      ea_q      <= '0;
      operand_q <= '0;
      opp_q     <= '0;
      cnt_q     <= '0;
      we_q      <= '0;
      pc_inc_q  <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aaa_q     <= aaa_d;
      bbb_q     <= bbb_d;
      lo_q      <= lo_d;
      ptr_q     <= ptr_d;
      ea_q      <= ea_d;
      operand_q <= operand_d;
      opp_q     <= opp_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      pc_inc_q  <= pc_inc_d;
      start_q   <= start_d;
      done_q    <= done_d;
      ill_q     <= ill_d;
      fault_q   <= fault_d;
    end
  end

  assign instr_ready       = (state_q == S_IDLE);
  assign alu_update_status = is_alu && (state_q == S_EXEC ||
                             state_q == S_ALU_WAIT || state_q == S_WB);
  assign ea         = ea_q;
  assign operand    = operand_q;
  assign opp        = opp_q;
  assign we         = we_q;
  assign pc_inc     = pc_inc_q;
  assign alu_start  = start_q;
  assign instr_done = done_q;
  assign illegal    = ill_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer with a byte memory, a fetch-side
// program counter and a fixed-latency ALU responder.
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_in;
  logic        pc_inc;
  logic [7:0]  x_in, y_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] ea;
  logic [7:0]  operand;
  logic [2:0]  opp;
  logic        alu_start, alu_done, alu_update_status;
  logic [2:0]  we;
  logic        instr_done, illegal, fault;

  always #5 clk = ~clk;

  decode_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_in(pc_in), .pc_inc(pc_inc),
    .x_in(x_in), .y_in(y_in),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ea(ea), .operand(operand), .opp(opp),
    .alu_start(alu_start), .alu_done(alu_done),
    .alu_update_status(alu_update_status), .we(we),
    .instr_done(instr_done), .illegal(illegal), .fault(fault)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log [0:255];
  logic [15:0] pc_base = 16'h0;
  logic [15:0] pc_off = 16'h0;
  int mem_wait = 0;
  int wait_cnt = 0;
  int rd_cnt = 0;
  int alu_lat = 0;
  int alu_cnt = 0;

  assign mem_ack   = mem_req && (wait_cnt >= mem_wait);
  assign mem_rdata = mem[mem_addr];
  assign pc_in     = pc_base + pc_off;
  assign alu_done  = (alu_cnt == 1);

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_req && mem_ack) begin
      rd_log[rd_cnt % 256] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
      if (mem_addr == pc_in) pc_off <= pc_off + 16'd1;
    end
    if (alu_start) alu_cnt <= alu_lat;
    else if (alu_cnt > 0) alu_cnt <= alu_cnt - 1;
  end

  int total = 0;
  int bad = 0;
  int cyc_done, n_pcinc, n_we, n_start, n_ill, nrd, rd0;
  logic [2:0]  we_at, we_after, opp_at;
  logic [15:0] ea_at, madr_at;
  logic [7:0]  op_at;
  logic        ill_at, flt_at, aus_seen, done_after;

  task automatic set_pc(input logic [15:0] a);
    pc_base = a - pc_off;
  endtask

  task automatic run(input logic [7:0] opc, input bit hold);
    n_pcinc = 0; n_we = 0; n_start = 0; n_ill = 0;
    aus_seen = 1'b0; cyc_done = -1;
    we_at = '0; opp_at = '0; ea_at = '0; madr_at = '0;
    op_at = '0; ill_at = 1'b0; flt_at = 1'b0;
    rd0 = rd_cnt;
    instr_in = opc;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) instr_in = 8'h89;
    else instr_valid = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (pc_inc) n_pcinc++;
      if (we != 3'b000) n_we++;
      if (alu_start) n_start++;
      if (alu_update_status) aus_seen = 1'b1;
      if (illegal && !instr_done) n_ill++;
      if (instr_done) begin
        cyc_done = c;
        we_at = we; ea_at = ea; op_at = operand;
        ill_at = illegal; flt_at = fault;
        madr_at = mem_addr; opp_at = opp;
        break;
      end
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;
    we_after = we;
    done_after = instr_done;
    nrd = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flags = {instr_ready, mem_req, pc_inc, alu_start,
             alu_update_status, instr_done, illegal, fault};
    total++;
    if (flags !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=%b", flags, 8'b1000_0000);
    end
    total++;
    if ({we, ea, operand, opp, mem_addr} !== 46'd0) begin
      bad++; $display("FAIL reset_regs we=%b ea=%h op=%h opp=%h addr=%h",
                      we, ea, operand, opp, mem_addr);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_pc(16'h8000);
    mem[16'h8000] = 8'h34;
    mem[16'h8001] = 8'h12;
    mem_wait = 4;
    instr_in = 8'hAD;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 0; k < 20 && !pc_inc; k++) begin
      @(posedge clk); #1;
    end
    total++;
    if (pc_inc !== 1'b1) begin
      bad++; $display("FAIL reset_oplo_timeout got=%b exp=1", pc_inc);
    end
    @(posedge clk); #1;
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h8001}) begin
      bad++; $display("FAIL reset_in_ophi req=%b addr=%h exp=1/8001",
                      mem_req, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    flags = {instr_ready, mem_req, pc_inc, alu_start,
             alu_update_status, instr_done, illegal, fault};
    total++;
    if (flags !== 8'b1000_0000 || we !== 3'b000) begin
      bad++; $display("FAIL reset_abort flags=%b we=%b exp=10000000/000",
                      flags, we);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (we !== 3'b000 || instr_done !== 1'b0) begin
      bad++; $display("FAIL reset_leak we=%b done=%b exp=000/0", we, instr_done);
    end
    reset_n = 1'b1;
    mem_wait = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_lda_imm();
    set_pc(16'h8000);
    mem[16'h8000] = 8'h5A;
    run(8'hA9, 1'b0);
    total++;
    if (cyc_done !== 2) begin
      bad++; $display("FAIL imm_latency got=%0d exp=2", cyc_done);
    end
    total++;
    if (op_at !== 8'h5A) begin
      bad++; $display("FAIL imm_operand got=%h exp=5a", op_at);
    end
    total++;
    if (we_at !== 3'b011 || n_we !== 1 || we_after !== 3'b000) begin
      bad++; $display("FAIL imm_we got=%b n=%0d after=%b exp=011/1/000",
                      we_at, n_we, we_after);
    end
    total++;
    if (n_pcinc !== 1 || nrd !== 1) begin
      bad++; $display("FAIL imm_fetch pcinc=%0d reads=%0d exp=1/1", n_pcinc, nrd);
    end
  endtask

  task automatic test_lda_zpx_wrap();
    set_pc(16'h8100);
    mem[16'h8100] = 8'hF0;
    mem[16'h0010] = 8'h77;
    x_in = 8'h20;
    run(8'hB5, 1'b0);
    total++;
    if (ea_at !== 16'h0010 || rd_log[(rd0 + 1) % 256] !== 16'h0010) begin
      bad++; $display("FAIL zpx_ea ea=%h read=%h exp=0010",
                      ea_at, rd_log[(rd0 + 1) % 256]);
    end
    total++;
    if (op_at !== 8'h77 || cyc_done !== 3 || we_at !== 3'b011) begin
      bad++; $display("FAIL zpx_result op=%h cyc=%0d we=%b exp=77/3/011",
                      op_at, cyc_done, we_at);
    end
  endtask

  task automatic test_lda_indirect();
    set_pc(16'h8200);
    mem[16'h8200] = 8'hFE;
    mem[16'h00FF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h1234] = 8'h99;
    x_in = 8'h01;
    run(8'hA1, 1'b0);
    total++;
    if (ea_at !== 16'h1234 || op_at !== 8'h99 || cyc_done !== 5) begin
      bad++; $display("FAIL izx ea=%h op=%h cyc=%0d exp=1234/99/5",
                      ea_at, op_at, cyc_done);
    end
    total++;
    if (rd_log[(rd0 + 1) % 256] !== 16'h00FF ||
        rd_log[(rd0 + 2) % 256] !== 16'h0000) begin
      bad++; $display("FAIL izx_ptr r1=%h r2=%h exp=00ff/0000",
                      rd_log[(rd0 + 1) % 256], rd_log[(rd0 + 2) % 256]);
    end
    set_pc(16'h8300);
    mem[16'h8300] = 8'hFF;
    mem[16'h1244] = 8'hC3;
    y_in = 8'h10;
    run(8'hB1, 1'b0);
    total++;
    if (ea_at !== 16'h1244 || op_at !== 8'hC3 || cyc_done !== 5) begin
      bad++; $display("FAIL izy ea=%h op=%h cyc=%0d exp=1244/c3/5",
                      ea_at, op_at, cyc_done);
    end
    total++;
    if (nrd !== 4 || rd_log[(rd0 + 3) % 256] !== 16'h1244) begin
      bad++; $display("FAIL izy_reads n=%0d last=%h exp=4/1244",
                      nrd, rd_log[(rd0 + 3) % 256]);
    end
  endtask

  task automatic test_sta_absx();
    set_pc(16'h8400);
    mem[16'h8400] = 8'hFF;
    mem[16'h8401] = 8'h12;
    x_in = 8'h01;
    run(8'h9D, 1'b0);
    total++;
    if (ea_at !== 16'h1300 || madr_at !== 16'h1300) begin
      bad++; $display("FAIL sta_ea ea=%h addr=%h exp=1300", ea_at, madr_at);
    end
    total++;
    if (we_at !== 3'b100 || n_we !== 1 || we_after !== 3'b000) begin
      bad++; $display("FAIL sta_we got=%b n=%0d after=%b exp=100/1/000",
                      we_at, n_we, we_after);
    end
    total++;
    if (nrd !== 2 || n_pcinc !== 2 || n_start !== 0 || cyc_done !== 3) begin
      bad++; $display("FAIL sta_seq reads=%0d pcinc=%0d start=%0d cyc=%0d exp=2/2/0/3",
                      nrd, n_pcinc, n_start, cyc_done);
    end
  endtask

  task automatic test_illegal();
    run(8'h89, 1'b0);
    total++;
    if (ill_at !== 1'b1 || cyc_done !== 0 || n_we !== 0 || nrd !== 0) begin
      bad++; $display("FAIL ill_89 ill=%b cyc=%0d we=%0d reads=%0d exp=1/0/0/0",
                      ill_at, cyc_done, n_we, nrd);
    end
    run(8'hA6, 1'b0);
    total++;
    if (ill_at !== 1'b1 || cyc_done !== 0 || done_after !== 1'b0) begin
      bad++; $display("FAIL ill_a6 ill=%b cyc=%0d after=%b exp=1/0/0",
                      ill_at, cyc_done, done_after);
    end
  endtask

  task automatic test_alu_timeout();
    set_pc(16'h8500);
    mem[16'h8500] = 8'h01;
    alu_lat = 0;
    run(8'h69, 1'b0);
    total++;
    if (flt_at !== 1'b1 || cyc_done !== 17) begin
      bad++; $display("FAIL timeout fault=%b cyc=%0d exp=1/17", flt_at, cyc_done);
    end
    total++;
    if (n_we !== 0 || n_start !== 1 || opp_at !== 3'd3 || aus_seen !== 1'b1) begin
      bad++; $display("FAIL timeout_side we=%0d start=%0d opp=%0d aus=%b exp=0/1/3/1",
                      n_we, n_start, opp_at, aus_seen);
    end
  endtask

  task automatic test_alu_ops();
    set_pc(16'h8600);
    mem[16'h8600] = 8'h42;
    alu_lat = 3;
    run(8'hC9, 1'b0);
    total++;
    if (we_at !== 3'b010 || cyc_done !== 7 || flt_at !== 1'b0) begin
      bad++; $display("FAIL cmp we=%b cyc=%0d fault=%b exp=010/7/0",
                      we_at, cyc_done, flt_at);
    end
    total++;
    if (opp_at !== 3'd4 || op_at !== 8'h42) begin
      bad++; $display("FAIL cmp_opp opp=%0d op=%h exp=4/42", opp_at, op_at);
    end
    set_pc(16'h8700);
    mem[16'h8700] = 8'hF0;
    mem[16'h8701] = 8'h12;
    mem[16'h1310] = 8'hAA;
    y_in = 8'h20;
    alu_lat = 1;
    run(8'h59, 1'b0);
    total++;
    if (ea_at !== 16'h1310 || op_at !== 8'hAA || cyc_done !== 7) begin
      bad++; $display("FAIL eor_absy ea=%h op=%h cyc=%0d exp=1310/aa/7",
                      ea_at, op_at, cyc_done);
    end
    total++;
    if (we_at !== 3'b011 || opp_at !== 3'd2) begin
      bad++; $display("FAIL eor_we we=%b opp=%0d exp=011/2", we_at, opp_at);
    end
    alu_lat = 0;
  endtask

  task automatic test_back_to_back();
    set_pc(16'h8800);
    mem[16'h8800] = 8'h40;
    mem[16'h0040] = 8'h11;
    run(8'hA5, 1'b1);
    total++;
    if (n_ill !== 0 || ill_at !== 1'b0 || op_at !== 8'h11 || cyc_done !== 3) begin
      bad++; $display("FAIL busy_valid ill=%0d/%b op=%h cyc=%0d exp=0/0/11/3",
                      n_ill, ill_at, op_at, cyc_done);
    end
    set_pc(16'h8900);
    mem[16'h8900] = 8'h3C;
    run(8'hA9, 1'b0);
    total++;
    if (op_at !== 8'h3C || cyc_done !== 2) begin
      bad++; $display("FAIL b2b op=%h cyc=%0d exp=3c/2", op_at, cyc_done);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    instr_in = 8'h00;
    instr_valid = 1'b0;
    x_in = 8'h00;
    y_in = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_lda_imm();
    test_lda_zpx_wrap();
    test_lda_indirect();
    test_sta_absx();
    test_illegal();
    test_alu_timeout();
    test_alu_ops();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Parametrised second-generation 6502 decode sequencer for the group-one opcode set (ORA, AND, EOR, ADC, STA, LDA, CMP, SBC) across all eight addressing modes. It accepts an opcode over a valid/ready handshake and fetches operand bytes and indirect pointers through a request/acknowledge memory port. It computes the effective address with 6502 wrap rules, drives the ALU with a start/done handshake and a timeout, and issues one-cycle register write enables. It sits between the fetch stage and the register file/ALU, in place of the single-mode decoder.

## Interface
- REG_WIDTH, `REG_WIDTH: data/register width (8 for 6502).
- ADDR_WIDTH, `ADDR_WIDTH: address width.
- OPP_WIDTH, `OPP_WIDTH: ALU opcode width.
- WE_WIDTH, `WE_WIDTH: write-enable vector width.
- ALU_TIMEOUT, 15: maximum cycles to wait for alu_done.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_in  in  REG_WIDTH  opcode byte.
- instr_valid  in  1  opcode present.
- instr_ready  out  1  sequencer idle; accepts the opcode this cycle.
- pc_in  in  ADDR_WIDTH  address of the next program byte.
- pc_inc  out  1  one-cycle pulse for each operand byte consumed.
- x_in, y_in  in  REG_WIDTH  index registers.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_WIDTH  read or write address.
- mem_ack  in  1  read data valid / access complete.
- mem_rdata  in  REG_WIDTH  read data.
- ea  out  ADDR_WIDTH  effective address; held until instr_done.
- operand  out  REG_WIDTH  fetched operand; held until instr_done.
- opp  out  OPP_WIDTH  ALU operation.
- alu_start  out  1  one-cycle ALU launch.
- alu_done  in  1  ALU result ready.
- alu_update_status  out  1  ALU is to update flags.
- we  out  WE_WIDTH  one-hot-per-target write enables (`WE_ADD, `WE_STAT, `WE_DOUT).
- instr_done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- fault  out  1  one-cycle pulse for an ALU timeout.

## Operation
- **Decode:** aaa = instr[7:5], bbb = instr[4:2], cc = instr[1:0]. Only cc=01 is legal; STA with bbb=010 (0x89) is illegal.
- **States:** IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, READ, EXEC, ALU_WAIT, WRITEBACK.
- **IDLE:** accepts the opcode on instr_valid&&instr_ready.
  - Illegal opcode: next cycle pulses illegal and instr_done, then returns to IDLE. No memory access, we=0.
  - Legal opcode: goes to OP_LO.
- **OP_LO / OP_HI:** mem_addr=pc_in, mem_req=1. On mem_ack the byte is captured and pc_inc pulses. OP_HI is used only for the abs modes (bbb=011/110/111).
- **Effective address** (all zero-page arithmetic is mod 256):
  - zp: {0,op}.
  - zp,X: {0,op+X}.
  - abs: {hi,lo}.
  - abs,X and abs,Y: {hi,lo}+X or +Y, mod 2^ADDR_WIDTH.
  - (zp,X): PTR_LO reads (op+X), PTR_HI reads (op+X+1).
  - (zp),Y: PTR_LO reads op, PTR_HI reads op+1; ea={hi,lo}+Y.
  - #imm: operand=op, no READ.
- **READ:** mem_addr=ea, mem_req=1; operand is captured on mem_ack. STA skips READ.
- **STA:** WRITEBACK drives mem_addr=ea and we[`WE_DOUT]=1 for one cycle.
- **LDA:** WRITEBACK asserts we[`WE_ADD] and we[`WE_STAT].
- **ALU ops:** EXEC pulses alu_start. opp mapping: ORA→`OR, AND→`AND, EOR→`XOR, ADC→`SUM, CMP/SBC→`SUB.
  - alu_update_status=1 from EXEC through WRITEBACK.
  - ALU_WAIT exits on alu_done to WRITEBACK: we[`WE_STAT]=1, plus we[`WE_ADD]=1 except for CMP.
  - If ALU_TIMEOUT cycles pass with no alu_done: pulse fault and instr_done, no we, return to IDLE.
- **Completion:** instr_done pulses in the WRITEBACK cycle, then the state returns to IDLE.

## Timing
- **Reset:** all outputs 0 except instr_ready=1; state=IDLE. Reset mid-instruction aborts immediately and no write enable leaks.
- **Memory handshake:** mem_req stays high for the whole memory state; the state advances on the edge where mem_ack=1. mem_ack with mem_req=0 is ignored. Zero-wait memory (ack in the same cycle as req) costs one cycle per access.
- **Zero-wait latency**, from the accept edge to instr_done:
  - #imm LDA: 2 cycles.
  - zp LDA: 3 cycles.
  - abs LDA: 4 cycles.
  - (zp),Y LDA: 5 cycles.
  - ALU ops: the same as LDA, plus EXEC, plus the ALU wait.
- **Handshake rules:**
  - instr_valid outside IDLE is ignored.
  - alu_done outside ALU_WAIT is ignored.
  - alu_done on the timeout cycle counts as done.
- **Outputs:** we, pc_inc, alu_start, instr_done, illegal and fault are registered single-cycle pulses.

## Test plan
- **Reset:** assert reset_n=0 mid-OP_HI with mem_ack pending → all outputs 0, instr_ready=1. The next opcode is accepted normally.
- **LDA #imm:** 0xA9 then operand 0x5A, zero-wait memory → operand=0x5A, we[`WE_ADD]=we[`WE_STAT]=1, instr_done 2 cycles after accept, one pc_inc.
- **LDA zp,X wrap:** 0xB5 with op=0xF0, X=0x20 → read at 0x0010.
- **LDA (zp),Y:** 0xB1 with op=0xFF, mem[0xFF]=0x34, mem[0x00]=0x12, Y=0x10 → ea=0x1244.
- **STA abs,X:** 0x9D with bytes 0xFF,0x12 and X=0x01 → ea=0x1300, we[`WE_DOUT]=1 for one cycle, no READ, two pc_inc.
- **Illegal and timeout:** 0x89 → illegal and instr_done next cycle, we=0. 0x69 #imm with alu_done never returned → fault after 15 cycles, we=0. 0xC9 (CMP) with alu_done after 3 cycles → we[`WE_STAT]=1, we[`WE_ADD]=0.
